img_write_router: RTL and testbench
===================================

# img_write_router

Parametrised write router between the image-memory-pool clients and the banked image pool. It replaces the fixed three-client, per-group write path with SRC_NUM generic sources, a shared arbitration pointer with fixed-priority or round-robin mode, and atomic multicast to several groups. It adds registered bank-side outputs and a saturating counter for misrouted requests. It sits in mem_pool_top between the conv, misc and load engines (and any later clients) and the IMG_GRP_NUM×ROW_PARA bank array.

## Interface
- SRC_NUM, 3, number of write sources; index 0 has the highest fixed priority.
- IMG_GRP_NUM, 3, number of image groups.
- ROW_PARA, 4, banks per group.
- CHL_PARA, 8, units per bank word.
- BANK_ADDR_WIDTH, 12, address width per bank.
- BANK_UNIT_WIDTH, 8, bits per unit.
- ARB_MODE, 0, 0 = fixed priority, 1 = round-robin.
- CNT_WIDTH, 16, width of drop counter.
- Derived: BW = BANK_UNIT_WIDTH*CHL_PARA, DW = ROW_PARA*BW, AW = ROW_PARA*BANK_ADDR_WIDTH.
- clk  in  1  single clock; all state is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_valid_i  in  SRC_NUM  request valid per source.
- src_group_id_i  in  SRC_NUM*IMG_GRP_NUM  target group mask per source; multiple bits means multicast.
- src_bank_en_i  in  SRC_NUM*ROW_PARA  bank write enables per source.
- src_addr_i  in  SRC_NUM*AW  per-bank addresses per source.
- src_data_i  in  SRC_NUM*DW  per-bank data per source.
- src_ready_o  out  SRC_NUM  grant; transfer occurs when valid&ready.
- write_bank_en_o  out  IMG_GRP_NUM*ROW_PARA  registered bank enables to pool.
- write_addr_o  out  IMG_GRP_NUM*AW  registered addresses.
- write_data_o  out  IMG_GRP_NUM*DW  registered data.
- drop_cnt_o  out  CNT_WIDTH  saturating count of dropped requests.

## Operation
- Slice layout: source s / group g occupy the s-th / g-th slice, LSB first. Same rule within AW and DW per bank.
- Arbitration is combinational each cycle and starts from pointer ptr (0..SRC_NUM-1).
  - Visit sources in order ptr, ptr+1, … modulo SRC_NUM.
  - A valid source with a non-zero mask is granted if none of its target groups is already claimed this cycle; it then claims all of them.
- Multicast is atomic: a source is granted for all target groups in one cycle or not at all. Partial writes never occur.
- Granted sources do not block disjoint requests: several sources with non-overlapping masks are granted in the same cycle.
- A valid request with an all-zero mask is granted immediately, writes nothing, and increments drop_cnt_o. It does not claim groups.
- Grants with src_bank_en slice = 0 are legal; they consume the group claim but write no bank.
- src_ready_o may depend combinationally on src_valid_i. A source must hold its request stable until granted.
- Pointer update:
  - ARB_MODE=0: ptr is constant 0.
  - ARB_MODE=1: on any cycle with at least one grant to a non-zero mask, ptr becomes (first such granted source in visit order)+1 mod SRC_NUM. Otherwise ptr holds.
- Output register, per group g:
  - Claimed by source s: next write_bank_en_o slice = s's bank_en; addr/data slices load s's addr/data.
  - Unclaimed: bank_en slice = 0; addr/data slices hold their previous value.
- drop_cnt_o saturates at 2^CNT_WIDTH-1 and never wraps. Several drops in one cycle add their count, clipped to saturation.

## Timing
- Reset (rst_n low, asynchronous): write_bank_en_o, write_addr_o, write_data_o = 0; drop_cnt_o = 0; ptr = 0. src_ready_o = 0 while rst_n is low.
- Latency: handshake in cycle N, bank write visible on write_*_o in cycle N+1. One request per group per cycle, so full throughput with no contention.
- Reset asserted mid-stream: registered outputs clear immediately, in-flight writes are lost, and the next grant after release starts from ptr = 0.
- Release: first grant is possible on the first rising edge with rst_n high.
- No backpressure from the pool; the pool accepts every cycle.

## Test plan
- Reset: hold rst_n=0 with all sources valid -> every output 0, src_ready_o=0; release -> outputs 0 until the first grant.
- Single write: src1 mask 3'b010, bank_en 4'b1010, addr bank1=0x123, bank3=0x456 -> src_ready_o=3'b010 at cycle N; at N+1 write_bank_en_o group1 slice = 4'b1010 with addresses 0x123/0x456; other groups 0, their addr/data unchanged.
- Fixed priority, ARB_MODE=0: src0, src1, src2 all target group 0 for 3 cycles -> src0 granted every cycle, src1/src2 ready stay 0.
- Round-robin, ARB_MODE=1: same stimulus, held until granted -> grants in order src0, src1, src2, src0.
- Multicast atomicity: src0 mask 3'b011 and src1 mask 3'b110 in the same cycle -> only src0 granted (groups 0,1). Next cycle src1 is granted; group2 is never written in the first cycle.
- Drop saturation, CNT_WIDTH=4: src2 valid with mask 0 for 20 cycles -> src_ready_o[2]=1 every cycle, no bank_en asserted, drop_cnt_o stops at 15.

Source files
------------

// File: rtl/img_write_router.sv
// Write router from SRC_NUM pool clients to the IMG_GRP_NUM x ROW_PARA bank array.
// Atomic multicast arbitration, registered bank-side outputs, saturating drop counter.
`timescale 1ns/1ps
module img_write_router #(
  parameter int SRC_NUM         = 3,
  parameter int IMG_GRP_NUM     = 3,
  parameter int ROW_PARA        = 4,
  parameter int CHL_PARA        = 8,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int BANK_UNIT_WIDTH = 8,
  parameter int ARB_MODE        = 0,
  parameter int CNT_WIDTH       = 16,
  localparam int BW = BANK_UNIT_WIDTH * CHL_PARA,
  localparam int DW = ROW_PARA * BW,
  localparam int AW = ROW_PARA * BANK_ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [SRC_NUM-1:0]              src_valid_i,
  input  logic [SRC_NUM*IMG_GRP_NUM-1:0]  src_group_id_i,
  input  logic [SRC_NUM*ROW_PARA-1:0]     src_bank_en_i,
  input  logic [SRC_NUM*AW-1:0]           src_addr_i,
  input  logic [SRC_NUM*DW-1:0]           src_data_i,
  output logic [SRC_NUM-1:0]              src_ready_o,
  output logic [IMG_GRP_NUM*ROW_PARA-1:0] write_bank_en_o,
  output logic [IMG_GRP_NUM*AW-1:0]       write_addr_o,
  output logic [IMG_GRP_NUM*DW-1:0]       write_data_o,
  output logic [CNT_WIDTH-1:0]            drop_cnt_o
);

  localparam int PW  = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
  localparam int DNW = $clog2(SRC_NUM + 1);

  logic [PW-1:0]                   ptr;
  logic [PW-1:0]                   ptr_nxt;
  logic                            ptr_upd;
  logic [SRC_NUM-1:0]              grant;
  logic [IMG_GRP_NUM-1:0]          claim;
  logic [DNW-1:0]                  drop_n;
  logic [IMG_GRP_NUM-1:0]          mask;
  int                              s_idx;
  logic [IMG_GRP_NUM*ROW_PARA-1:0] en_nxt;
  logic [IMG_GRP_NUM*AW-1:0]       addr_nxt;
  logic [IMG_GRP_NUM*DW-1:0]       data_nxt;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [DNW-1:0]       b);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + (CNT_WIDTH+1)'(b);
    sat_add = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

  // Stage 0: visit sources from ptr; a source wins only if every target group is still free
  always_comb begin
    grant    = '0;
    claim    = '0;
    drop_n   = '0;
    ptr_upd  = 1'b0;
    ptr_nxt  = ptr;
    mask     = '0;
    s_idx    = 0;
    en_nxt   = '0;
    addr_nxt = write_addr_o;
    data_nxt = write_data_o;
    for (int i = 0; i < SRC_NUM; i++) begin
      s_idx = (int'(ptr) + i) % SRC_NUM;
      mask  = src_group_id_i[s_idx*IMG_GRP_NUM +: IMG_GRP_NUM];
      if (rst_n && src_valid_i[s_idx]) begin
        if (mask == '0) begin
          grant[s_idx] = 1'b1;
          drop_n       = drop_n + DNW'(1);
        end else if ((mask & claim) == '0) begin
          grant[s_idx] = 1'b1;
          claim        = claim | mask;
          for (int g = 0; g < IMG_GRP_NUM; g++) begin
            if (mask[g]) begin
              en_nxt[g*ROW_PARA +: ROW_PARA] = src_bank_en_i[s_idx*ROW_PARA +: ROW_PARA];
              addr_nxt[g*AW +: AW]           = src_addr_i[s_idx*AW +: AW];
              data_nxt[g*DW +: DW]           = src_data_i[s_idx*DW +: DW];
            end
          end
          if (!ptr_upd) begin
            ptr_upd = 1'b1;
            ptr_nxt = (s_idx == SRC_NUM - 1) ? '0 : PW'(s_idx + 1);
          end
        end
      end
    end
  end

  assign src_ready_o = grant;

  // Stage 1: bank-side register; unclaimed groups keep addr/data and drop their enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr             <= '0;
      write_bank_en_o <= '0;
      write_addr_o    <= '0;
      write_data_o    <= '0;
      drop_cnt_o      <= '0;
    end else begin
      if (ARB_MODE == 1 && ptr_upd) ptr <= ptr_nxt;
      write_bank_en_o <= en_nxt;
      write_addr_o    <= addr_nxt;
      write_data_o    <= data_nxt;
      drop_cnt_o      <= sat_add(drop_cnt_o, drop_n);
    end
  end

endmodule

// File: tb/tb_img_write_router.sv
// Bench for img_write_router: a fixed-priority and a round-robin instance on shared stimulus,
// checked every cycle against a queue-free behavioural model plus directed literal checks.
`timescale 1ns/1ps
module tb_img_write_router;
  localparam int SRC = 3, G = 3, RP = 4, CHL = 8, BAW = 12, BUW = 8;
  localparam int BW = BUW * CHL, DW = RP * BW, AW = RP * BAW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [SRC-1:0]    valid = '0;
  logic [SRC*G-1:0]  gid   = '0;
  logic [SRC*RP-1:0] ben   = '0;
  logic [SRC*AW-1:0] addr  = '0;
  logic [SRC*DW-1:0] data  = '0;

  logic [SRC-1:0]  rdy_fp, rdy_rr;
  logic [G*RP-1:0] en_fp, en_rr;
  logic [G*AW-1:0] wa_fp, wa_rr;
  logic [G*DW-1:0] wd_fp, wd_rr;
  logic [3:0]      cnt_fp;
  logic [15:0]     cnt_rr;

  always #5 clk = ~clk;

  img_write_router #(.SRC_NUM(SRC), .IMG_GRP_NUM(G), .ROW_PARA(RP), .CHL_PARA(CHL),
    .BANK_ADDR_WIDTH(BAW), .BANK_UNIT_WIDTH(BUW), .ARB_MODE(0), .CNT_WIDTH(4)) u_fp (
    .clk(clk), .rst_n(rst_n), .src_valid_i(valid), .src_group_id_i(gid),
    .src_bank_en_i(ben), .src_addr_i(addr), .src_data_i(data), .src_ready_o(rdy_fp),
    .write_bank_en_o(en_fp), .write_addr_o(wa_fp), .write_data_o(wd_fp), .drop_cnt_o(cnt_fp));

  img_write_router #(.SRC_NUM(SRC), .IMG_GRP_NUM(G), .ROW_PARA(RP), .CHL_PARA(CHL),
    .BANK_ADDR_WIDTH(BAW), .BANK_UNIT_WIDTH(BUW), .ARB_MODE(1), .CNT_WIDTH(16)) u_rr (
    .clk(clk), .rst_n(rst_n), .src_valid_i(valid), .src_group_id_i(gid),
    .src_bank_en_i(ben), .src_addr_i(addr), .src_data_i(data), .src_ready_o(rdy_rr),
    .write_bank_en_o(en_rr), .write_addr_o(wa_rr), .write_data_o(wd_rr), .drop_cnt_o(cnt_rr));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: index 0 = fixed priority / 4-bit counter, index 1 = round-robin / 16-bit counter
  int              m_mode[2] = '{0, 1};
  int              m_cmax[2] = '{15, 65535};
  int              m_ptr[2];
  int              m_cnt[2];
  logic [G*RP-1:0] m_en[2];
  logic [G*AW-1:0] m_addr[2];
  logic [G*DW-1:0] m_data[2];
  logic [SRC-1:0]  e_gnt[2];
  int              e_own[2][G];
  int              e_drops[2];
  int              e_first[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_cnt[k] = 0; m_en[k] = '0; m_addr[k] = '0; m_data[k] = '0;
    end
  endtask

  task automatic model_arb(input int k);
    int s;
    logic [G-1:0] m;
    bit free;
    e_gnt[k] = '0; e_drops[k] = 0; e_first[k] = -1;
    for (int g = 0; g < G; g++) e_own[k][g] = -1;
    for (int n = 0; n < SRC; n++) begin
      s = (m_ptr[k] + n) % SRC;
      m = gid[s*G +: G];
      if (rst_n && valid[s]) begin
        if (m == '0) begin
          e_gnt[k][s] = 1'b1;
          e_drops[k]++;
        end else begin
          free = 1'b1;
          for (int g = 0; g < G; g++) if (m[g] && e_own[k][g] >= 0) free = 1'b0;
          if (free) begin
            e_gnt[k][s] = 1'b1;
            for (int g = 0; g < G; g++) if (m[g]) e_own[k][g] = s;
            if (e_first[k] < 0) e_first[k] = s;
          end
        end
      end
    end
  endtask

  task automatic model_step(input int k);
    int o;
    for (int g = 0; g < G; g++) begin
      o = e_own[k][g];
      if (o >= 0) begin
        m_en[k][g*RP +: RP]   = ben[o*RP +: RP];
        m_addr[k][g*AW +: AW] = addr[o*AW +: AW];
        m_data[k][g*DW +: DW] = data[o*DW +: DW];
      end else begin
        m_en[k][g*RP +: RP] = '0;
      end
    end
    m_cnt[k] = (m_cnt[k] + e_drops[k] > m_cmax[k]) ? m_cmax[k] : m_cnt[k] + e_drops[k];
    if (m_mode[k] == 1 && e_first[k] >= 0) m_ptr[k] = (e_first[k] + 1) % SRC;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      for (int k = 0; k < 2; k++) model_arb(k);
      chk("ready_fp", rdy_fp, e_gnt[0]);
      chk("ready_rr", rdy_rr, e_gnt[1]);
      chk("bank_en_fp", en_fp, m_en[0]);
      chk("bank_en_rr", en_rr, m_en[1]);
      chk("addr_fp", wa_fp, m_addr[0]);
      chk("addr_rr", wa_rr, m_addr[1]);
      chk("data_fp", wd_fp, m_data[0]);
      chk("data_rr", wd_rr, m_data[1]);
      chk("drop_cnt_fp", cnt_fp, m_cnt[0]);
      chk("drop_cnt_rr", cnt_rr, m_cnt[1]);
      @(posedge clk);
      if (rst_n) for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  task automatic clr();
    valid = '0; gid = '0; ben = '0; addr = '0; data = '0;
  endtask

  task automatic set_src(input int s, input logic [G-1:0] m, input logic [RP-1:0] be);
    valid[s] = 1'b1;
    gid[s*G +: G] = m;
    ben[s*RP +: RP] = be;
    for (int b = 0; b < RP; b++) addr[s*AW + b*BAW +: BAW] = BAW'($urandom);
    for (int w = 0; w < DW/32; w++) data[s*DW + w*32 +: 32] = $urandom;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  logic [SRC-1:0] rr_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [SRC-1:0] g_prev;

  initial begin
    #1 rst_n = 1'b0;
    valid = '1; gid = '1; ben = '1;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_ready_fp", rdy_fp, 3'b000);
    chk("rst_ready_rr", rdy_rr, 3'b000);
    chk("rst_en_fp", en_fp, 12'h000);
    chk("rst_cnt_rr", cnt_rr, 16'd0);
    next_cycle();
    clr();
    rst_n = 1'b1;
    next_cycle();
    chk("release_en_fp", en_fp, 12'h000);

    // single write from src1 to group1
    set_src(1, 3'b010, 4'b1010);
    addr[1*AW + 1*BAW +: BAW] = 12'h123;
    addr[1*AW + 3*BAW +: BAW] = 12'h456;
    #1;
    chk("single_ready_fp", rdy_fp, 3'b010);
    chk("single_ready_rr", rdy_rr, 3'b010);
    @(posedge clk); #1;
    clr();
    chk("single_en", en_fp, 12'h0A0);
    chk("single_addr_b1", wa_fp[AW + 1*BAW +: BAW], 12'h123);
    chk("single_addr_b3", wa_fp[AW + 3*BAW +: BAW], 12'h456);
    chk("single_addr_g0", wa_fp[0 +: AW], 48'h0);
    #1;

    // fixed priority: everyone wants group 0
    for (int s = 0; s < SRC; s++) set_src(s, 3'b001, 4'b1111);
    repeat (3) begin
      #1 chk("fixed_prio_ready", rdy_fp, 3'b001);
      @(posedge clk); #1;
    end
    clr();

    // round-robin from a freshly reset pointer
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int s = 0; s < SRC; s++) set_src(s, 3'b001, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_order", rdy_rr, rr_seq[i]);
      @(posedge clk); #1;
    end
    clr();

    // multicast atomicity
    set_src(0, 3'b011, 4'b1111);
    set_src(1, 3'b110, 4'b1111);
    #1 chk("mcast_ready0", rdy_fp, 3'b001);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    chk("mcast_grp2_idle", en_fp[2*RP +: RP], 4'b0000);
    chk("mcast_grp01", en_fp[0 +: 2*RP], 8'hFF);
    #1 chk("mcast_ready1", rdy_fp, 3'b010);
    @(posedge clk); #1;
    chk("mcast_second", en_fp, 12'hFF0);
    clr();

    // drop-counter saturation
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    set_src(2, 3'b000, 4'b1111);
    repeat (20) begin
      #1 chk("drop_ready", rdy_fp[2], 1'b1);
      @(posedge clk); #1;
      chk("drop_no_en", en_fp, 12'h000);
    end
    chk("drop_sat_fp", cnt_fp, 4'd15);
    chk("drop_cnt_rr", cnt_rr, 16'd20);
    clr();

    // random traffic, sources hold until the round-robin instance grants them
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      g_prev = rdy_rr;
      @(posedge clk);
      #2;
      if (cyc == 403) rst_n = 1'b1;
      for (int s = 0; s < SRC; s++) begin
        if (!(valid[s] && !g_prev[s])) begin
          if ($urandom_range(0, 9) < 7) set_src(s, G'($urandom_range(0, 7)), RP'($urandom));
          else valid[s] = 1'b0;
        end
      end
      if (cyc == 400) begin
        rst_n = 1'b0;
        #1;
        chk("async_clr_en_fp", en_fp, 12'h000);
        chk("async_clr_en_rr", en_rr, 12'h000);
        chk("async_clr_data_rr", wd_rr, '0);
        chk("async_clr_cnt_rr", cnt_rr, 16'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
